kpn_fifo_channel: RTL and testbench

- Bounded FIFO channel carrying 16-bit tokens between KPN processes. Sits directly upstream of the split process and drives its entry_1 input.
- Producer-side writes are qualified by wr. Consumer-side reads are qualified by rd, using the same rd/wr strobe style the process modules already drive.
- Provides full/empty back-pressure and an occupancy count, so process nodes block per KPN semantics instead of losing tokens.

---
 rtl/kpn_fifo_channel.sv | 121 ++++++++++++
 tb/tb_kpn_fifo_channel.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/kpn_fifo_channel.sv
// Bounded FIFO channel carrying tokens between KPN processes, with registered full/empty/count.
// Optional feature macro KPN_FIFO_ERR_EN adds sticky overflow_err/underflow_err outputs.
module kpn_fifo_channel #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
`ifdef KPN_FIFO_ERR_EN
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow_err,
    output logic                  underflow_err
`else
    output logic [ADDR_WIDTH:0]   count
`endif
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  wr_ok, rd_ok;

    // Both strobes are qualified by the registered flags, so a read never frees a slot
    // for a same-cycle write, and a write is never bypassed to a same-cycle read.
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;

        wr_ok = wr && !full_q;
        rd_ok = rd && !empty_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            data_out_d = mem[rd_ptr_q];
        end

        if (wr_ok && !rd_ok) begin
            count_d = count_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - 1'b1;
        end

        full_d  = (count_d == FULL_COUNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so all state updates see pre-edge values.
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
        end
    end

    // NOTE: storage has no reset; a slot is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign data_out = data_out_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;

`ifdef KPN_FIFO_ERR_EN
    logic overflow_err_q, overflow_err_d;
    logic underflow_err_q, underflow_err_d;

    always_comb begin
        overflow_err_d  = overflow_err_q  || (wr && full_q);
        underflow_err_d = underflow_err_q || (rd && empty_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_err_q  <= 1'b0;
            underflow_err_q <= 1'b0;
        end else begin
            overflow_err_q  <= overflow_err_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    assign overflow_err  = overflow_err_q;
    assign underflow_err = underflow_err_q;
`endif

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// Self-checking bench for kpn_fifo_channel: directed scenarios plus randomized traffic
// checked against a queue-based channel model.
module tb_kpn_fifo_channel;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
`ifdef KPN_FIFO_ERR_EN
    logic          overflow_err;
    logic          underflow_err;
`endif

    kpn_fifo_channel #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .data_in      (data_in),
        .rd           (rd),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
`ifdef KPN_FIFO_ERR_EN
        .count        (count),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err)
`else
        .count        (count)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Channel model: a bounded queue of tokens in arrival order.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;

    function automatic logic [AW:0] m_count();
        return (AW + 1)'(q.size());
    endfunction

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // One clock: drive strobes, apply the channel rules to the model at the edge,
    // then return 1 time unit after the edge with strobes released.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        bit rd_acc, wr_acc;
        wr = w; data_in = d; rd = r;
        @(posedge clk);
        if (w && q.size() == DEPTH) m_ovf = 1'b1;
        if (r && q.size() == 0)     m_unf = 1'b1;
        rd_acc = r && (q.size() > 0);
        wr_acc = w && (q.size() < DEPTH);
        if (rd_acc) m_dout = q.pop_front();
        if (wr_acc) q.push_back(d);
        #1;
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_total++; if (data_out !== 16'h0000) $display("FAIL reset_dout: got %h want 0000", data_out); else n_pass++;
        n_total++; if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else n_pass++;
`ifdef KPN_FIFO_ERR_EN
        n_total++; if ({overflow_err, underflow_err} !== 2'b00) $display("FAIL reset_err: got %b want 00", {overflow_err, underflow_err}); else n_pass++;
`endif
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        step(1'b0, '0, 1'b0);
        n_total++; if (empty !== 1'b1 || count !== 4'd0) $display("FAIL idle_after_reset: got empty=%b count=%0d want 1/0", empty, count); else n_pass++;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 16'(i), 1'b0);
            n_total++; if (count !== 4'(i)) $display("FAIL fill_count: got %0d want %0d", count, i); else n_pass++;
        end
        n_total++; if (full !== 1'b1 || count !== 4'd8) $display("FAIL fill_full: got full=%b count=%0d want 1/8", full, count); else n_pass++;
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, '0, 1'b1);
            n_total++; if (data_out !== 16'(i)) $display("FAIL drain_dout: got %h want %h", data_out, 16'(i)); else n_pass++;
        end
        n_total++; if (empty !== 1'b1 || full !== 1'b0 || count !== 4'd0) $display("FAIL drain_end: got empty=%b full=%b count=%0d want 1/0/0", empty, full, count); else n_pass++;
    endtask

    task automatic test_overflow_underflow();
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 16'(i), 1'b0);
        step(1'b1, 16'hDEAD, 1'b0);
        n_total++; if (count !== 4'd8 || full !== 1'b1) $display("FAIL ovf_count: got count=%0d full=%b want 8/1", count, full); else n_pass++;
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, '0, 1'b1);
            n_total++; if (data_out !== 16'(i)) $display("FAIL ovf_drain: got %h want %h", data_out, 16'(i)); else n_pass++;
        end
        step(1'b0, '0, 1'b1);
        n_total++; if (data_out !== 16'h0008 || count !== 4'd0 || empty !== 1'b1) $display("FAIL unf_hold: got dout=%h count=%0d empty=%b want 0008/0/1", data_out, count, empty); else n_pass++;
`ifdef KPN_FIFO_ERR_EN
        n_total++; if ({overflow_err, underflow_err} !== 2'b11) $display("FAIL err_sticky: got %b want 11", {overflow_err, underflow_err}); else n_pass++;
        step(1'b0, '0, 1'b0);
        n_total++; if ({overflow_err, underflow_err} !== 2'b11) $display("FAIL err_hold: got %b want 11", {overflow_err, underflow_err}); else n_pass++;
`endif
    endtask

    task automatic test_simultaneous();
        step(1'b1, 16'h1234, 1'b1);
        n_total++; if (count !== 4'd1 || data_out !== 16'h0008) $display("FAIL sim_empty: got count=%0d dout=%h want 1/0008", count, data_out); else n_pass++;
        step(1'b1, 16'h2222, 1'b0);
        step(1'b1, 16'h3333, 1'b0);
        step(1'b1, 16'h5678, 1'b1);
        n_total++; if (count !== 4'd3 || data_out !== 16'h1234) $display("FAIL sim_mid: got count=%0d dout=%h want 3/1234", count, data_out); else n_pass++;
        for (int i = 0; i < 5; i++) step(1'b1, 16'h4000 + 16'(i), 1'b0);
        n_total++; if (full !== 1'b1) $display("FAIL sim_prefull: got full=%b want 1", full); else n_pass++;
        step(1'b1, 16'hBEEF, 1'b1);
        n_total++; if (count !== 4'd7 || data_out !== 16'h2222) $display("FAIL sim_full: got count=%0d dout=%h want 7/2222", count, data_out); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, '0, 1'b1);
            n_total++; if (data_out !== m_dout || data_out === 16'hBEEF) $display("FAIL sim_drain: got %h want %h", data_out, m_dout); else n_pass++;
        end
        n_total++; if (empty !== 1'b1) $display("FAIL sim_end_empty: got %b want 1", empty); else n_pass++;
    endtask

    task automatic test_wraparound();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'h0100 + 16'(i), 1'b0);
            n_total++; if (count > 4'd1) $display("FAIL wrap_count: got %0d want <=1", count); else n_pass++;
            step(1'b0, '0, 1'b1);
            n_total++; if (data_out !== 16'h0100 + 16'(i)) $display("FAIL wrap_order: got %h want %h", data_out, 16'h0100 + 16'(i)); else n_pass++;
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0700 + 16'(i), 1'b0);
        n_total++; if (count !== 4'd5) $display("FAIL mid_precount: got %0d want 5", count); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || data_out !== 16'h0000) $display("FAIL mid_reset: got count=%0d empty=%b full=%b dout=%h want 0/1/0/0000", count, empty, full, data_out); else n_pass++;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        step(1'b1, 16'hAAAA, 1'b0);
        step(1'b0, '0, 1'b1);
        n_total++; if (data_out !== 16'hAAAA || empty !== 1'b1) $display("FAIL mid_fresh: got dout=%h empty=%b want aaaa/1", data_out, empty); else n_pass++;
`ifdef KPN_FIFO_ERR_EN
        n_total++; if ({overflow_err, underflow_err} !== 2'b00) $display("FAIL mid_err_clear: got %b want 00", {overflow_err, underflow_err}); else n_pass++;
`endif
    endtask

    task automatic test_random();
        int n_bad = 0;
        for (int i = 0; i < 400; i++) begin
            // Bias toward writes in the first half and reads in the second to hit both bounds.
            bit w = ($urandom_range(99) < ((i < 200) ? 70 : 30));
            bit r = ($urandom_range(99) < ((i < 200) ? 30 : 70));
            step(w, 16'($urandom), r);
            n_total++;
            if (data_out !== m_dout || count !== m_count() || full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin
                if (n_bad < 10) $display("FAIL rand_cycle%0d: got dout=%h count=%0d full=%b empty=%b want %h/%0d/%b/%b",
                    i, data_out, count, full, empty, m_dout, m_count(), q.size() == DEPTH, q.size() == 0);
                n_bad++;
            end else n_pass++;
`ifdef KPN_FIFO_ERR_EN
            n_total++;
            if (overflow_err !== m_ovf || underflow_err !== m_unf) $display("FAIL rand_err%0d: got %b%b want %b%b", i, overflow_err, underflow_err, m_ovf, m_unf);
            else n_pass++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_simultaneous();
        test_wraparound();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
